// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch front end for the single-cycle core. It owns the PC, issues word
//   fetches to instruction memory, tags each request with its PC, and buffers
//   returned words in an in-order queue. The head {instr, pc} goes to decode
//   over a valid/ready handshake. A redirect flushes the queue and discards
//   every response that is still in flight.
//
//   Optional feature macro: IFQ_BYPASS_EN
//     defined   : a response arriving while the queue is empty is presented to
//                 decode combinationally in the same cycle. It is not enqueued
//                 if decode consumes it in that cycle.
//     undefined : the output comes only from the registered queue head.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous reset, active-low
//   start_i        in   fetching enabled while high
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch byte address, word aligned
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   response valid (in request order)
//   imem_rdata_i   in   response instruction word
//   redirect_i     in   1-cycle flush / refetch pulse
//   redirect_pc_i  in   redirect target (bits [1:0] ignored)
//   instr_valid_o  out  head entry valid
//   instr_o        out  head instruction
//   instr_pc_o     out  byte address of instr_o
//   instr_ready_i  in   decode consumes the head when valid && ready
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] count_q, outstanding_q, discard_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q, tag_rd_q, tag_wr_q;

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   tag_q  [DEPTH];

    logic [CW:0]   inflight;
    logic          fire, resp_keep, head_valid, bypass, enq, deq;
    logic [31:0]   resp_pc;

    // Credit: queued entries plus requests in flight never exceed DEPTH,
    // so every response is guaranteed a queue slot.
    assign inflight = {1'b0, count_q} + {1'b0, outstanding_q};

    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                imem_req_o = (inflight < (CW+1)'(DEPTH));
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr_o = fetch_pc_q;
    assign fire        = imem_req_o && imem_gnt_i;
    assign resp_keep   = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign resp_pc     = tag_q[tag_rd_q];
    assign head_valid  = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = resp_keep && !head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid_o = head_valid || bypass;
    assign instr_o       = head_valid ? data_q[rd_ptr_q] : (bypass ? imem_rdata_i : '0);
    assign instr_pc_o    = head_valid ? pc_q[rd_ptr_q]   : (bypass ? resp_pc      : '0);

    assign deq = head_valid && instr_ready_i;
    // A bypassed word taken by decode this cycle never occupies a slot.
    assign enq = resp_keep && !(bypass && instr_ready_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
            if (fire)          tag_wr_q <= tag_wr_q + 1'b1;
            if (imem_rvalid_i) tag_rd_q <= tag_rd_q + 1'b1;

            if (redirect_i) begin
                // Everything still in flight after this edge, including a
                // grant taken this cycle, belongs to the old stream.
                discard_q  <= outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
                fetch_pc_q <= redirect_pc_i & ~32'h3;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (imem_rvalid_i && (discard_q != '0)) discard_q <= discard_q - 1'b1;
                if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(enq) - CW'(deq);
            end
        end
    end

    // Storage arrays carry no reset; the output mux gates them with count.
    always_ff @(posedge clk_i) begin
        if (fire) tag_q[tag_wr_q] <= fetch_pc_q;
        if (enq && !redirect_i) begin
            data_q[wr_ptr_q] <= imem_rdata_i;
            pc_q[wr_ptr_q]   <= resp_pc;
        end
    end

    rvalid_needs_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_i) imem_rvalid_i |-> (outstanding_q != '0)
    );

endmodule
